mda_vram_sequencer: RTL and testbench

//  Character-clock sequencer and VRAM arbiter for the MDA display path. Generates the
//  18-phase clk_seq and the per-character strobes consumed by mda_pixel, and shares a

---
 rtl/mda_vram_sequencer.sv | 155 +++++++++++++++
 tb/tb_mda_vram_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mda_vram_sequencer.sv
// mda_vram_sequencer
//   Character-clock sequencer and VRAM arbiter for the MDA display path.
//   An 18-phase counter (clk_seq) paces each character time. Phases 0 and 1
//   fetch the character and attribute bytes for the CRTC address. CPU
//   accesses are confined to fixed slots inside the character, so the
//   display fetch never stalls.
//
//   Build option: define MDA_SEQ_FAST_CPU_EN for four CPU slots
//   (phases 6, 9, 12, 15). Without it, the two slots are CPU_SLOT_A and
//   CPU_SLOT_B.
//
// Ports
//   clk, reset                 pixel clock; asynchronous active-high reset
//   crtc_addr[10:0]            character address, sampled at phase 17
//   crtc_clk                   character-clock enable (phase 17)
//   clk_seq[4:0]               phase counter 0..17
//   vram_read_char / _att      phase 1 / phase 2 strobes
//   charrom_read, disp_pipeline phase 17 strobes
//   vram_addr/we/din           synchronous VRAM port
//   vram_dout[7:0]             VRAM data, one cycle after the address
//   cpu_req/we/addr/wdata      CPU request (level, held until cpu_ack)
//   cpu_rdata[7:0], cpu_ack    read data and single-cycle completion pulse
module mda_vram_sequencer #(
    parameter int CPU_SLOT_A = 6,
    parameter int CPU_SLOT_B = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] crtc_addr,
    output logic        crtc_clk,
    output logic [4:0]  clk_seq,
    output logic        vram_read_char,
    output logic        vram_read_att,
    output logic        charrom_read,
    output logic        disp_pipeline,
    output logic [11:0] vram_addr,
    output logic        vram_we,
    output logic [7:0]  vram_din,
    input  logic [7:0]  vram_dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_ACCESS,
        S_DONE
    } cpu_state_t;

`ifndef MDA_SEQ_FAST_CPU_EN
    if (CPU_SLOT_A < 4 || CPU_SLOT_A > 15 || CPU_SLOT_B < 4 || CPU_SLOT_B > 15 ||
        CPU_SLOT_B < CPU_SLOT_A + 3) begin : g_bad_slots
        $error("mda_vram_sequencer: illegal CPU slot parameters");
    end

    localparam logic [4:0] PRE_A = 5'(CPU_SLOT_A - 1);
    localparam logic [4:0] PRE_B = 5'(CPU_SLOT_B - 1);
`endif

    cpu_state_t  state, state_next;
    logic        acc_half;        // second cycle of ACCESS (RAM data returning)
    logic        we_lat;
    logic [10:0] crtc_addr_lat;
    logic [4:0]  seq_next;
    logic        grant;

    // True in the cycle just before a CPU slot: the request is latched at
    // this edge so the access is presented during the slot phase itself.
    function automatic logic is_pre_slot(input logic [4:0] seq);
`ifdef MDA_SEQ_FAST_CPU_EN
        return (seq == 5'd5) || (seq == 5'd8) || (seq == 5'd11) || (seq == 5'd14);
`else
        return (seq == PRE_A) || (seq == PRE_B);
`endif
    endfunction

    assign seq_next = (clk_seq == 5'd17) ? 5'd0 : clk_seq + 5'd1;
    assign grant    = (state == S_PEND) && cpu_req && is_pre_slot(clk_seq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            acc_half <= 1'b0;
        end else begin
            state    <= state_next;
            acc_half <= (state == S_ACCESS) && !acc_half;
        end
    end

    // DONE is the ack cycle; a request still held there is ignored so the
    // same request is not served twice.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (cpu_req) state_next = S_PEND;
            S_PEND: begin
                if (!cpu_req)   state_next = S_IDLE;
                else if (grant) state_next = S_ACCESS;
            end
            S_ACCESS: if (acc_half) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_seq        <= 5'd0;
            crtc_clk       <= 1'b0;
            vram_read_char <= 1'b0;
            vram_read_att  <= 1'b0;
            charrom_read   <= 1'b0;
            disp_pipeline  <= 1'b0;
            vram_addr      <= 12'd0;
            vram_we        <= 1'b0;
            vram_din       <= 8'd0;
            cpu_rdata      <= 8'd0;
            cpu_ack        <= 1'b0;
            crtc_addr_lat  <= 11'd0;
            we_lat         <= 1'b0;
        end else begin
            // Strobes are decoded from the next phase so they are high
            // exactly while clk_seq shows their phase.
            clk_seq        <= seq_next;
            crtc_clk       <= (seq_next == 5'd17);
            charrom_read   <= (seq_next == 5'd17);
            disp_pipeline  <= (seq_next == 5'd17);
            vram_read_char <= (seq_next == 5'd1);
            vram_read_att  <= (seq_next == 5'd2);
            vram_we        <= 1'b0;

            if (clk_seq == 5'd17) begin
                crtc_addr_lat <= crtc_addr;
                vram_addr     <= {crtc_addr, 1'b0};
            end else if (clk_seq == 5'd0) begin
                vram_addr     <= {crtc_addr_lat, 1'b1};
            end else if (grant) begin
                vram_addr <= cpu_addr;
                vram_din  <= cpu_wdata;
                vram_we   <= cpu_we;
                we_lat    <= cpu_we;
            end

            if (state == S_ACCESS && acc_half && !we_lat)
                cpu_rdata <= vram_dout;
            cpu_ack <= (state == S_ACCESS) && acc_half;
        end
    end

endmodule

// File: tb/tb_mda_vram_sequencer.sv
module tb_mda_vram_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] crtc_addr = 11'h123;
    logic        crtc_clk;
    logic [4:0]  clk_seq;
    logic        vram_read_char, vram_read_att, charrom_read, disp_pipeline;
    logic [11:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_din;
    logic [7:0]  vram_dout;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [11:0] cpu_addr = 12'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:4095];

    mda_vram_sequencer dut (
        .clk(clk), .reset(reset), .crtc_addr(crtc_addr), .crtc_clk(crtc_clk),
        .clk_seq(clk_seq), .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
        .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_din(vram_din),
        .vram_dout(vram_dout), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk) begin
        if (vram_we) mem[vram_addr] <= vram_din;
        vram_dout <= mem[vram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns mid-cycle (negedge) of the next cycle in which clk_seq == p.
    task automatic goto_phase(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clk_seq != 5'(p) && n < 40);
        if (clk_seq != 5'(p)) check("goto_phase_timeout", 32'(clk_seq), 32'(p));
    endtask

    // One CPU transaction: request raised during start_ph, optionally dropped
    // during drop_ph (-1 = held until ack). Observes 40 cycles.
    task automatic cpu_txn(input string tag, input logic we, input logic [11:0] addr,
                           input logic [7:0] data, input int start_ph, input int drop_ph,
                           input int exp_we_cnt, input int exp_we_ph,
                           input int exp_ack_cnt, input int exp_ack_ph,
                           input logic [7:0] exp_rdata);
        int we_cnt = 0, we_ph = -1, ack_cnt = 0, ack_ph = -1;
        logic [11:0] we_addr = 12'd0;
        logic [7:0]  we_din = 8'd0, ack_rdata = 8'd0;
        goto_phase(start_ph);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (vram_we) begin
                we_cnt++; we_ph = int'(clk_seq); we_addr = vram_addr; we_din = vram_din;
            end
            if (cpu_ack) begin
                ack_cnt++; ack_ph = int'(clk_seq); ack_rdata = cpu_rdata;
                cpu_req = 1'b0;
            end
            if (drop_ph >= 0 && int'(clk_seq) == drop_ph && c < 18) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        check({tag, "_we_cnt"}, 32'(we_cnt), 32'(exp_we_cnt));
        check({tag, "_ack_cnt"}, 32'(ack_cnt), 32'(exp_ack_cnt));
        if (exp_we_cnt > 0) begin
            check({tag, "_we_phase"}, 32'(we_ph), 32'(exp_we_ph));
            check({tag, "_we_addr"}, 32'(we_addr), 32'(addr));
            check({tag, "_we_din"}, 32'(we_din), 32'(data));
        end
        if (exp_ack_cnt > 0) check({tag, "_ack_phase"}, 32'(ack_ph), 32'(exp_ack_ph));
        if (!we && exp_ack_cnt > 0) begin
            check({tag, "_rdata_at_ack"}, 32'(ack_rdata), 32'(exp_rdata));
            check({tag, "_rdata_held"}, 32'(cpu_rdata), 32'(exp_rdata));
        end
    endtask

`ifdef MDA_SEQ_FAST_CPU_EN
    localparam int P5_ACC = 9,  P5_ACK = 11;
    localparam int P11_ACC = 15, P11_ACK = 17;
    localparam int P13_ACC = 15, P13_ACK = 17;
`else
    localparam int P5_ACC = 12, P5_ACK = 14;
    localparam int P11_ACC = 6,  P11_ACK = 8;
    localparam int P13_ACC = 6,  P13_ACK = 8;
`endif

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Reset state
        #12;
        check("rst_clk_seq", 32'(clk_seq), 0);
        check("rst_strobes", {27'd0, crtc_clk, vram_read_char, vram_read_att,
                              charrom_read, disp_pipeline}, 0);
        check("rst_vram_addr", 32'(vram_addr), 0);
        check("rst_vram_we_din", {23'd0, vram_we, vram_din}, 0);
        check("rst_cpu", {23'd0, cpu_ack, cpu_rdata}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Display fetch and per-character strobes
        goto_phase(0);
        check("disp_addr_ph0", 32'(vram_addr), 32'h246);
        for (int p = 0; p < 18; p++) begin
            logic [4:0] exp_s;
            if (p > 0) @(negedge clk);
            exp_s = {(p == 17), (p == 1), (p == 2), (p == 17), (p == 17)};
            check($sformatf("strobes_ph%0d", p), {27'd0, crtc_clk, vram_read_char,
                  vram_read_att, charrom_read, disp_pipeline}, 32'(exp_s));
            if (p == 1) check("disp_addr_ph1", 32'(vram_addr), 32'h247);
        end

        // CPU write then read-back
        cpu_txn("wr_0a0", 1'b1, 12'h0A0, 8'h5A, 2, -1, 1, 6, 1, 8, 8'h00);
        cpu_txn("rd_0a0", 1'b0, 12'h0A0, 8'h00, 2, -1, 0, 0, 1, 8, 8'h5A);

        // Late requests miss the slot right after them
        cpu_txn("wr_ph5", 1'b1, 12'h0B1, 8'h3C, 5, -1, 1, P5_ACC, 1, P5_ACK, 8'h00);
        cpu_txn("rd_ph11", 1'b0, 12'h0B1, 8'h00, 11, -1, 0, 0, 1, P11_ACK, 8'h3C);
        cpu_txn("wr_ph13", 1'b1, 12'h0B2, 8'hC3, 13, -1, 1, P13_ACC, 1, P13_ACK, 8'h00);
        cpu_txn("rd_ph13", 1'b0, 12'h0B2, 8'h00, 13, -1, 0, 0, 1, P13_ACK, 8'hC3);

        // Abandoned request, then a request dropped after grant
        cpu_txn("drop_pre", 1'b1, 12'h0C0, 8'hFF, 2, 4, 0, 0, 0, 0, 8'h00);
        cpu_txn("rd_0c0", 1'b0, 12'h0C0, 8'h00, 2, -1, 0, 0, 1, 8, 8'h00);
        cpu_txn("drop_post", 1'b1, 12'h0D0, 8'h77, 2, 6, 1, 6, 1, 8, 8'h00);
        cpu_txn("rd_0d0", 1'b0, 12'h0D0, 8'h00, 2, -1, 0, 0, 1, 8, 8'h77);

        // Asynchronous reset in the middle of a write access
        goto_phase(2);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h0E0; cpu_wdata = 8'h11;
        goto_phase(6);
        check("acc_we_before_rst", 32'(vram_we), 1);
        #1 reset = 1'b1;
        #1;
        check("arst_vram_we", 32'(vram_we), 0);
        check("arst_clk_seq", 32'(clk_seq), 0);
        check("arst_vram_addr", 32'(vram_addr), 0);
        check("arst_vram_din", 32'(vram_din), 0);
        check("arst_cpu_rdata", 32'(cpu_rdata), 0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("arst_held_ack", 32'(cpu_ack), 0);
        reset = 1'b0;
        for (int i = 0; i < 19; i++) begin
            check($sformatf("seq_run_%0d", i), 32'(clk_seq), 32'(i % 18));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
